// File: rtl/pc_sequencer.sv
// Program counter register with stall hold, branch/jump redirect and a circular
// return-address stack for jump-and-link / jump-register returns.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        Link,
    input  logic        Return,
    input  logic [31:0] ReturnFallback,
    output logic [31:0] PCResult,
    output logic [3:0]  RASCount,
    output logic        RASOverflow,
    output logic        Misaligned
);

    localparam int unsigned PtrW     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [3:0]  DepthCnt = 4'(RAS_DEPTH);

    logic [31:0]     pc_q, pc_d;
    logic [PtrW-1:0] ptr_q, ptr_d, ptr_dec;
    logic [3:0]      cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            push;
    logic [31:0]     ras_q [RAS_DEPTH];

    assign ptr_dec = ptr_q - PtrW'(1);

    always_comb begin
        pc_d  = PCAddResult;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        push  = 1'b0;
        if (Stall) begin
            pc_d = pc_q;
        end else if (Return) begin
            if (cnt_q != 4'd0) begin
                pc_d  = ras_q[ptr_dec];
                ptr_d = ptr_dec;
                cnt_d = cnt_q - 4'd1;
            end else begin
                pc_d = ReturnFallback;
            end
        end else if (Jump) begin
            pc_d = JumpTarget;
            if (Link) begin
                push  = 1'b1;
                ptr_d = ptr_q + PtrW'(1);
                // A full stack overwrites its oldest entry; the pointer wraps onto it.
                if (cnt_q == DepthCnt) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end else if (Branch) begin
            pc_d = BranchTarget;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q  <= RESET_PC;
            ptr_q <= '0;
            cnt_q <= 4'd0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Stack contents need no reset; the count qualifies them.
    always_ff @(posedge Clk) begin
        if (push && !Reset) begin
            ras_q[ptr_q] <= PCAddResult;
        end
    end

    assign PCResult    = pc_q;
    assign RASCount    = cnt_q;
    assign RASOverflow = ovf_q;
    assign Misaligned  = |pc_q[1:0];

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: expected PC/RAS state is queued as each cycle is
// driven and popped for comparison once the edge has registered it.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCAddResult;
    logic        Stall, Branch, Jump, Link, Return;
    logic [31:0] BranchTarget, JumpTarget, ReturnFallback;
    logic [31:0] PCResult;
    logic [3:0]  RASCount;
    logic        RASOverflow, Misaligned;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  cnt;
        logic        ovf;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mpc    = 32'h0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .RAS_DEPTH(4)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .PCAddResult    (PCAddResult),
        .Stall          (Stall),
        .Branch         (Branch),
        .BranchTarget   (BranchTarget),
        .Jump           (Jump),
        .JumpTarget     (JumpTarget),
        .Link           (Link),
        .Return         (Return),
        .ReturnFallback (ReturnFallback),
        .PCResult       (PCResult),
        .RASCount       (RASCount),
        .RASOverflow    (RASOverflow),
        .Misaligned     (Misaligned)
    );

    always #5 Clk = ~Clk;

    // Drive one cycle of controls, queue what the spec says the registers become, step the edge.
    task automatic apply(input logic rst, input logic st, input logic br, input logic [31:0] bt,
                         input logic jmp, input logic [31:0] jt, input logic lnk,
                         input logic rt, input logic [31:0] fb,
                         input logic [31:0] epc, input logic [3:0] ecnt, input logic eovf);
        exp_t e;
        Reset = rst; Stall = st; Branch = br; BranchTarget = bt;
        Jump = jmp; JumpTarget = jt; Link = lnk; Return = rt; ReturnFallback = fb;
        PCAddResult = mpc + 32'd4;
        e.pc = epc; e.cnt = ecnt; e.ovf = eovf; e.mis = |epc[1:0];
        sb.push_back(e);
        mpc = epc;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'(i * 4), 4'd0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (PCResult !== e.pc || RASCount !== e.cnt || RASOverflow !== e.ovf ||
                Misaligned !== e.mis) begin
                errors++;
                $display("FAIL reset step %0d: got pc=%h cnt=%0d ovf=%b mis=%b want pc=%h cnt=%0d ovf=%b mis=%b",
                         i, PCResult, RASCount, RASOverflow, Misaligned, e.pc, e.cnt, e.ovf, e.mis);
            end
        end
    endtask

    task automatic test_jal_return();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 4'd0, 1'b0);
                1: apply(0, 0, 0, 0, 1, 32'h100, 1, 0, 0, 32'h100, 4'd1, 1'b0);
                2: apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 4'd1, 1'b0);
                default: apply(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_0000, 32'h14, 4'd0, 1'b0);
            endcase
            e = sb.pop_front();
            checks++;
            if (PCResult !== e.pc || RASCount !== e.cnt || RASOverflow !== e.ovf ||
                Misaligned !== e.mis) begin
                errors++;
                $display("FAIL jal_return step %0d: got pc=%h cnt=%0d ovf=%b mis=%b want pc=%h cnt=%0d ovf=%b mis=%b",
                         i, PCResult, RASCount, RASOverflow, Misaligned, e.pc, e.cnt, e.ovf, e.mis);
            end
        end
    endtask

    task automatic test_overflow();
        exp_t        e;
        logic [31:0] ret_pc [4];
        ret_pc[0] = 32'h404; ret_pc[1] = 32'h304; ret_pc[2] = 32'h204; ret_pc[3] = 32'h104;
        for (int i = 0; i < 11; i++) begin
            if (i == 0) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'd0, 1'b0);
            else if (i <= 5)
                apply(0, 0, 0, 0, 1, mpc + 32'h100, 1, 0, 0, mpc + 32'h100,
                      (i < 4) ? 4'(i) : 4'd4, i == 5);
            else if (i <= 9)
                apply(0, 0, 0, 0, 0, 0, 0, 1, 32'hABC, ret_pc[i-6], 4'(9 - i), 1'b1);
            else apply(0, 0, 0, 0, 0, 0, 0, 1, 32'hABC, 32'hABC, 4'd0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (PCResult !== e.pc || RASCount !== e.cnt || RASOverflow !== e.ovf ||
                Misaligned !== e.mis) begin
                errors++;
                $display("FAIL overflow step %0d: got pc=%h cnt=%0d ovf=%b mis=%b want pc=%h cnt=%0d ovf=%b mis=%b",
                         i, PCResult, RASCount, RASOverflow, Misaligned, e.pc, e.cnt, e.ovf, e.mis);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'd0, 1'b0);
                1: apply(0, 0, 1, 32'h20, 0, 0, 0, 0, 0, 32'h20, 4'd0, 1'b0);
                2: apply(0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 32'h20, 4'd0, 1'b0);
                3: apply(0, 1, 1, 32'h40, 1, 32'h300, 1, 0, 0, 32'h20, 4'd0, 1'b0);
                4: apply(0, 1, 1, 32'h40, 0, 0, 0, 1, 32'h500, 32'h20, 4'd0, 1'b0);
                default: apply(0, 0, 1, 32'h40, 0, 0, 0, 0, 0, 32'h40, 4'd0, 1'b0);
            endcase
            e = sb.pop_front();
            checks++;
            if (PCResult !== e.pc || RASCount !== e.cnt || RASOverflow !== e.ovf ||
                Misaligned !== e.mis) begin
                errors++;
                $display("FAIL stall step %0d: got pc=%h cnt=%0d ovf=%b mis=%b want pc=%h cnt=%0d ovf=%b mis=%b",
                         i, PCResult, RASCount, RASOverflow, Misaligned, e.pc, e.cnt, e.ovf, e.mis);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: apply(0, 0, 1, 32'h7C, 0, 0, 0, 0, 0, 32'h7C, 4'd0, 1'b0);
                1: apply(0, 0, 0, 0, 1, 32'h200, 1, 0, 0, 32'h200, 4'd1, 1'b0);
                2: apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h204, 4'd1, 1'b0);
                default: apply(0, 0, 1, 32'h400, 1, 32'h300, 1, 1, 32'h600, 32'h80, 4'd0, 1'b0);
            endcase
            e = sb.pop_front();
            checks++;
            if (PCResult !== e.pc || RASCount !== e.cnt || RASOverflow !== e.ovf ||
                Misaligned !== e.mis) begin
                errors++;
                $display("FAIL priority step %0d: got pc=%h cnt=%0d ovf=%b mis=%b want pc=%h cnt=%0d ovf=%b mis=%b",
                         i, PCResult, RASCount, RASOverflow, Misaligned, e.pc, e.cnt, e.ovf, e.mis);
            end
        end
    endtask

    task automatic test_misaligned_reset();
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) apply(0, 0, 1, 32'h102, 0, 0, 0, 0, 0, 32'h102, 4'd0, 1'b0);
            else if (i <= 5)
                apply(0, 0, 0, 0, 1, 32'(32'h1000 + i * 16), 1, 0, 0, 32'(32'h1000 + i * 16),
                      (i < 4) ? 4'(i) : 4'd4, i == 5);
            else if (i == 6) apply(1, 0, 0, 0, 1, 32'h2000, 1, 0, 0, 32'h0, 4'd0, 1'b0);
            else if (i == 7) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 4'd0, 1'b0);
            else apply(0, 0, 0, 0, 0, 0, 0, 1, 32'h55C, 32'h55C, 4'd0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (PCResult !== e.pc || RASCount !== e.cnt || RASOverflow !== e.ovf ||
                Misaligned !== e.mis) begin
                errors++;
                $display("FAIL misaligned_reset step %0d: got pc=%h cnt=%0d ovf=%b mis=%b want pc=%h cnt=%0d ovf=%b mis=%b",
                         i, PCResult, RASCount, RASOverflow, Misaligned, e.pc, e.cnt, e.ovf, e.mis);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; Branch = 1'b0; Jump = 1'b0; Link = 1'b0; Return = 1'b0;
        BranchTarget = '0; JumpTarget = '0; ReturnFallback = '0; PCAddResult = 32'd4;
        test_reset();
        test_jal_return();
        test_overflow();
        test_stall();
        test_priority();
        test_misaligned_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
